pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencing unit for the 5-stage MIPS core. It is the consumer of the hazard unit's `stall` request and of ID-stage redirect and multi-cycle multiply/divide events.
- It drives the PC and IF/ID write enables, the IF/ID flush, and ID/EX bubble insertion.
- It tracks per-stage valid bits, runs the mult/div busy FSM, and keeps a stall performance counter.

Parameters:
- MD_CYCLES, 32, cycles a mult/div occupies the HI/LO unit; legal range 2..63.
- CNT_W, 6, width of the mult/div down-counter; must satisfy 2^CNT_W > MD_CYCLES.
- PERF_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_stall  in  1  load-use stall request from the hazard unit (combinational, ID stage).
- redirect  in  1  taken branch/jump resolved in ID this cycle.
- md_start  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- md_use  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO.
- perf_clr  in  1  synchronous clear of perf_stall.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  load NOP into IF/ID at the next edge.
- idex_bubble  out  1  load NOP into ID/EX at the next edge.
- id_valid, ex_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction.
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse: HI/LO result written.
- perf_stall  out  PERF_W  count of stalled cycles.

Behaviour:
- stall_any = ld_stall | (md_busy & (md_use | md_start)). This is combinational and gated by id_valid: a stall is raised only when id_valid=1.
- pc_we = ifid_we = ~stall_any.
- idex_bubble = stall_any | ~id_valid.
- ifid_flush = redirect & ~stall_any & id_valid. A redirect seen during a stall is ignored; it is re-presented when the stall clears.
- Valid chain, per rising edge:
  - id_valid <= ifid_flush ? 0 : (stall_any ? id_valid : 1).
  - ex_valid <= id_valid & ~stall_any.
  - mem_valid <= ex_valid.
  - wb_valid <= mem_valid.
- Mult/div FSM states:
  - IDLE: md_start & id_valid & ~stall_any -> BUSY, cnt <= MD_CYCLES-1.
  - BUSY: cnt decrements each cycle; cnt==0 -> DONE.
  - DONE: one cycle. md_start accepted this cycle -> BUSY with cnt reloaded; otherwise -> IDLE.
- FSM outputs and forwarding:
  - md_busy = (state==BUSY); md_done = (state==DONE).
  - md_use in DONE or IDLE does not stall; the result is forwarded by the datapath on md_done.
- Simultaneous events:
  - ld_stall with md_start: stall wins and md_start is not accepted; it is retried next cycle.
  - redirect with md_start, both accepted: md_start still launches (the branch delay-slot-free core squashes only IF).
- perf_stall:
  - Increments by 1 on each edge where stall_any=1.
  - Saturates at 2^PERF_W-1.
  - perf_clr has priority over increment and loads 0.
- Reset (rst_n=0, async, also mid-operation):
  - Registers: state=IDLE, cnt=0, all valid bits=0, perf_stall=0.
  - Outputs forced during reset: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1, md_busy=0, md_done=0.
  - First edge after release: id_valid=0 -> 1; the pipeline then fills one stage per cycle.

Test Plan:
- Reset release, no hazards -> id_valid high at edge 1, wb_valid high at edge 4; pc_we=1 throughout; perf_stall=0.
- ld_stall=1 for one cycle with id_valid=1 -> pc_we=ifid_we=0, idex_bubble=1 that cycle; ex_valid=0 next cycle, mem_valid=0 after; perf_stall=1.
- md_start accepted, MD_CYCLES=4 -> md_busy high exactly 4 cycles, md_done pulse on cycle 5. md_use asserted during BUSY stalls all 4 cycles; perf_stall=4.
- redirect=1 with ld_stall=1 -> ifid_flush=0. Next cycle redirect=1, ld_stall=0 -> ifid_flush=1, and id_valid=0 after the edge.
- Back-to-back md_start in DONE -> immediate return to BUSY, no IDLE cycle, md_done pulses once per operation.
- rst_n low mid-BUSY (cnt=2) -> md_busy=0 and valids=0 immediately without a clock. perf_stall at 2^16-1 with a stall holds its value; perf_clr together with a stall -> 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing for the 5-stage MIPS core.
// Owns stall/flush/bubble controls, stage valids, mult/div FSM, stall counter.
module pipe_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_stall,
    input  logic              redirect,
    input  logic              md_start,
    input  logic              md_use,
    input  logic              perf_clr,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              id_valid,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] perf_stall
);

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    localparam logic [CNT_W-1:0]  MD_LOAD  = CNT_W'(MD_CYCLES - 1);
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             stall_any;
    logic             md_accept;

    // Hazard resolution; outputs held safe while reset is asserted.
    always_comb begin
        stall_any   = id_valid &
                      (ld_stall | (md_busy & (md_use | md_start)));
        md_accept   = md_start & id_valid & ~stall_any & ~md_busy;
        pc_we       = rst_n & ~stall_any;
        ifid_we     = rst_n & ~stall_any;
        ifid_flush  = rst_n & redirect & ~stall_any & id_valid;
        idex_bubble = ~rst_n | stall_any | ~id_valid;
    end

    // Per-stage valid chain; a stall freezes ID and bubbles EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
        end else begin
            if (ifid_flush)
                id_valid <= 1'b0;
            else if (!stall_any)
                id_valid <= 1'b1;
            ex_valid  <= id_valid & ~stall_any;
            mem_valid <= ex_valid;
            wb_valid  <= mem_valid;
        end
    end

    // Mult/div occupancy FSM with registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    md_done <= 1'b0;
                    if (md_accept) begin
                        state   <= MD_BUSY;
                        cnt     <= MD_LOAD;
                        md_busy <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt == '0) begin
                        state   <= MD_DONE;
                        md_busy <= 1'b0;
                        md_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MD_DONE: begin
                    md_done <= 1'b0;
                    if (md_accept) begin
                        state   <= MD_BUSY;
                        cnt     <= MD_LOAD;
                        md_busy <= 1'b1;
                    end else begin
                        state <= MD_IDLE;
                    end
                end
                default: begin
                    state   <= MD_IDLE;
                    cnt     <= '0;
                    md_busy <= 1'b0;
                    md_done <= 1'b0;
                end
            endcase
        end
    end

    // Saturating stall counter; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_stall <= '0;
        else if (perf_clr)
            perf_stall <= '0;
        else if (stall_any && perf_stall != PERF_MAX)
            perf_stall <= perf_stall + 1'b1;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: random and directed stimulus for pipe_ctrl,
// checked every cycle against a timestamp-based behavioural model.
module tb_pipe_ctrl;

    localparam int MD = 4;
    localparam int PW = 16;
    localparam longint PMAX = (longint'(1) << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_stall = 1'b0;
    logic          redirect = 1'b0;
    logic          md_start = 1'b0;
    logic          md_use = 1'b0;
    logic          perf_clr = 1'b0;
    logic          pc_we, ifid_we, ifid_flush, idex_bubble;
    logic          id_valid, ex_valid, mem_valid, wb_valid;
    logic          md_busy, md_done;
    logic [PW-1:0] perf_stall;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(
        .MD_CYCLES(MD),
        .CNT_W(6),
        .PERF_W(PW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ld_stall(ld_stall),
        .redirect(redirect),
        .md_start(md_start),
        .md_use(md_use),
        .perf_clr(perf_clr),
        .pc_we(pc_we),
        .ifid_we(ifid_we),
        .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble),
        .id_valid(id_valid),
        .ex_valid(ex_valid),
        .mem_valid(mem_valid),
        .wb_valid(wb_valid),
        .md_busy(md_busy),
        .md_done(md_done),
        .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    // Model: stage valids as a list, mult/div as launch timestamp.
    bit     m_v [0:3];
    int     n;
    int     launch;
    bit     launched;
    longint m_perf;

    function automatic bit m_busy();
        return launched && (n - launch) >= 0 && (n - launch) < MD;
    endfunction

    function automatic bit m_done();
        return launched && (n - launch) == MD;
    endfunction

    function automatic bit m_stall();
        return m_v[0] && (ld_stall || (m_busy() && (md_use || md_start)));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_v[i] <= 1'b0;
            n        <= 0;
            launch   <= 0;
            launched <= 1'b0;
            m_perf   <= 0;
        end else begin
            m_v[3] <= m_v[2];
            m_v[2] <= m_v[1];
            m_v[1] <= m_v[0] && !m_stall();
            if (redirect && !m_stall() && m_v[0])
                m_v[0] <= 1'b0;
            else if (!m_stall())
                m_v[0] <= 1'b1;
            if (perf_clr)
                m_perf <= 0;
            else if (m_stall() && m_perf < PMAX)
                m_perf <= m_perf + 1;
            n <= n + 1;
            if (md_start && m_v[0] && !m_stall() && !m_busy()) begin
                launched <= 1'b1;
                launch   <= n + 1;
            end
        end
    end

    task automatic cmp(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic do_compare();
        bit es;
        es = rst_n && m_stall();
        cmp("pc_we", 64'(pc_we), 64'(rst_n && !es));
        cmp("ifid_we", 64'(ifid_we), 64'(rst_n && !es));
        cmp("ifid_flush", 64'(ifid_flush),
            64'(rst_n && redirect && !es && m_v[0]));
        cmp("idex_bubble", 64'(idex_bubble),
            64'(!rst_n || es || !m_v[0]));
        cmp("id_valid", 64'(id_valid), 64'(m_v[0]));
        cmp("ex_valid", 64'(ex_valid), 64'(m_v[1]));
        cmp("mem_valid", 64'(mem_valid), 64'(m_v[2]));
        cmp("wb_valid", 64'(wb_valid), 64'(m_v[3]));
        cmp("md_busy", 64'(md_busy), 64'(m_busy()));
        cmp("md_done", 64'(md_done), 64'(m_done()));
        cmp("perf_stall", 64'(perf_stall), 64'(m_perf));
    endtask

    always @(negedge clk) do_compare();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        cmp("lit_rst_pc_we", 64'(pc_we), 64'd0);
        cmp("lit_rst_bubble", 64'(idex_bubble), 64'd1);
        cmp("lit_rst_id_valid", 64'(id_valid), 64'd0);
        cmp("lit_rst_perf", 64'(perf_stall), 64'd0);
        #4 rst_n = 1'b1;

        // Fill from reset
        step();
        cmp("lit_fill_id", 64'(id_valid), 64'd1);
        cmp("lit_fill_ex", 64'(ex_valid), 64'd0);
        step(); step(); step();
        cmp("lit_fill_wb", 64'(wb_valid), 64'd1);
        cmp("lit_fill_pc_we", 64'(pc_we), 64'd1);
        cmp("lit_fill_perf", 64'(perf_stall), 64'd0);

        // One-cycle load-use stall
        ld_stall = 1'b1;
        #1;
        cmp("lit_ld_pc_we", 64'(pc_we), 64'd0);
        cmp("lit_ld_ifid_we", 64'(ifid_we), 64'd0);
        cmp("lit_ld_bubble", 64'(idex_bubble), 64'd1);
        step();
        ld_stall = 1'b0;
        #1;
        cmp("lit_ld_ex", 64'(ex_valid), 64'd0);
        cmp("lit_ld_perf", 64'(perf_stall), 64'd1);
        step();
        cmp("lit_ld_mem", 64'(mem_valid), 64'd0);

        // Mult/div with md_use stalling through BUSY
        md_start = 1'b1;
        step();
        md_start = 1'b0;
        md_use = 1'b1;
        #1;
        for (int i = 0; i < MD; i++) begin
            cmp("lit_md_busy", 64'(md_busy), 64'd1);
            cmp("lit_md_stall", 64'(pc_we), 64'd0);
            step();
        end
        #1;
        cmp("lit_md_busy_end", 64'(md_busy), 64'd0);
        cmp("lit_md_done", 64'(md_done), 64'd1);
        cmp("lit_md_use_done", 64'(pc_we), 64'd1);
        cmp("lit_md_perf", 64'(perf_stall), 64'd5);
        md_use = 1'b0;
        step();

        // Redirect during stall is held off
        redirect = 1'b1;
        ld_stall = 1'b1;
        #1;
        cmp("lit_rd_stall_flush", 64'(ifid_flush), 64'd0);
        step();
        ld_stall = 1'b0;
        #1;
        cmp("lit_rd_flush", 64'(ifid_flush), 64'd1);
        step();
        redirect = 1'b0;
        #1;
        cmp("lit_rd_id", 64'(id_valid), 64'd0);
        step();
        cmp("lit_rd_refill", 64'(id_valid), 64'd1);

        // Back-to-back mult/div
        md_start = 1'b1;
        step();
        md_start = 1'b0;
        repeat (MD) step();
        cmp("lit_b2b_done", 64'(md_done), 64'd1);
        md_start = 1'b1;
        step();
        md_start = 1'b0;
        #1;
        cmp("lit_b2b_busy", 64'(md_busy), 64'd1);
        cmp("lit_b2b_nodone", 64'(md_done), 64'd0);

        // Async reset mid-BUSY
        step();
        #1 rst_n = 1'b0;
        #1;
        do_compare();
        cmp("lit_ar_busy", 64'(md_busy), 64'd0);
        cmp("lit_ar_valids",
            64'({id_valid, ex_valid, mem_valid, wb_valid}), 64'd0);
        cmp("lit_ar_pc_we", 64'(pc_we), 64'd0);
        cmp("lit_ar_bubble", 64'(idex_bubble), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();

        // Saturation then clear with stall
        ld_stall = 1'b1;
        repeat (65540) step();
        cmp("lit_sat_perf", 64'(perf_stall), 64'(PMAX));
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        ld_stall = 1'b0;
        #1;
        cmp("lit_clr_perf", 64'(perf_stall), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            ld_stall = ($urandom_range(99) < 20);
            redirect = ($urandom_range(99) < 15);
            md_start = ($urandom_range(99) < 20);
            md_use   = ($urandom_range(99) < 25);
            perf_clr = ($urandom_range(99) < 3);
            if (i == 1500 || i == 2400) begin
                #1 rst_n = 1'b0;
                #1;
                do_compare();
                #1 rst_n = 1'b1;
            end
        end
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
